boot_seq_ctrl: RTL
==================

// Module: boot_seq_ctrl
// PURPOSE
// Boot sequencer and instruction-memory port arbiter inside top_core. Shares the single-port program
// memory between the SPI-slave write path and the core instruction-fetch port, detects end of program
// load, drives fetch_enable/en_ifetch, bounds run time with a cycle counter, and grades the final GPIO.
// Replaces host-side sequencing of program load -> fetch enable -> run window -> pass/fail check.
// PARAMETERS
// BASE_ADDR    32'h80        byte address of program-memory word 0
// MEM_WORDS    32            program-memory depth in 32-bit words (power of 2)
// END_MARKER   32'h00000fff  SPI write data value that terminates loading
// ARM_CYCLES   2             idle cycles between load done and fetch enable (>=1)
// RUN_CYCLES   400           cycles fetch stays enabled before grading (>=1)
// PASS_VALUE   32'd255       gpio_i value graded as pass
// PORTS
// clk_i          in   1   clock
// rst_ni         in   1   async active-low reset
// spi_req_i      in   1   SPI-side memory request (held until spi_gnt_o)
// spi_we_i       in   1   1=write, 0=read
// spi_addr_i     in   32  byte address
// spi_wdata_i    in   32  write data
// spi_gnt_o      out  1   request accepted this cycle
// spi_rvalid_o   out  1   read data valid (1 cycle after a granted read)
// spi_rdata_o    out  32  read data
// core_req_i     in   1   core instruction-fetch request
// core_addr_i    in   32  fetch byte address
// core_gnt_o     out  1   fetch accepted this cycle
// core_rvalid_o  out  1   fetch data valid (1 cycle after grant)
// core_rdata_o   out  32  fetch data
// mem_req_o/mem_we_o out 1  memory strobe / write enable
// mem_addr_o     out  $clog2(MEM_WORDS)  word index = (addr-BASE_ADDR)>>2
// mem_wdata_o    out  32  memory write data;  mem_rdata_i in 32: data 1 cycle after mem_req_o
// host_go_i      in   1   force LOAD->ARM without END_MARKER (1-cycle pulse)
// host_clear_i   in   1   return to LOAD from any state (1-cycle pulse)
// gpio_i         in   32  core GPIO output, sampled at end of run
// fetch_enable_o/en_ifetch_o out 1  core enables
// state_o out 3 current state; pass_o/fail_o out 1 sticky grade; addr_err_o out 1 sticky window error
// BEHAVIOUR
// - Reset: state LOAD, all outputs 0, counters 0, rdata outputs 0.
// - FSM: LOAD -> ARM on granted SPI write with wdata==END_MARKER in window, or host_go_i.
//   ARM: counts ARM_CYCLES, then RUN. RUN: fetch_enable_o=en_ifetch_o=1, counter 0..RUN_CYCLES-1;
//   at terminal count -> DONE, enables drop next cycle, gpio_i sampled that same cycle:
//   ==PASS_VALUE sets pass_o else fail_o. DONE holds until host_clear_i.
//   host_clear_i (any state, priority over all transitions) -> LOAD, clears pass/fail/addr_err, counters.
// - END_MARKER word is itself written to memory before the transition.
// - Arbitration: LOAD/ARM/DONE: SPI only, core_gnt_o=0. RUN: core has fixed priority; SPI granted
//   only in cycles with core_req_i=0. At most one grant per cycle. Grant is combinational on req.
// - Window: addr in [BASE_ADDR, BASE_ADDR+4*MEM_WORDS). Out-of-window SPI access: granted, no mem_req_o,
//   sets addr_err_o, read returns 32'h0 with rvalid; out-of-window core fetch: granted, returns 32'h0.
//   Low two address bits ignored.
// - rvalid routes mem_rdata_i to the requester that owned the previous-cycle grant (1-bit owner flop).
// - Async reset mid-RUN: enables drop immediately, memory contents untouched.
// STRUCTURE
// - Package boot_seq_pkg: state enum {LOAD,ARM,RUN,DONE} (3-bit), owner enum {OWN_SPI,OWN_CORE}.
// - One sub-module: boot_seq_arb (grant mux, window decode, owner flop, rdata steering); FSM and
//   counters stay in the top.
// TESTING
// - Load 4 words at 0x80..0x8C, last = 0x00000fff -> 4 mem writes, ARM 2 cycles, fetch_enable_o=1.
// - RUN with gpio_i=255 at terminal -> enables 1 for exactly 400 cycles, pass_o=1, fail_o=0.
// - RUN with gpio_i=254 -> fail_o=1; host_clear_i -> state LOAD, flags 0.
// - RUN, core_req_i and spi_req_i both 1 -> core_gnt_o=1, spi_gnt_o=0; next idle cycle SPI granted.
// - SPI write to 0x7C and 0x100 -> no mem_req_o, addr_err_o=1; read returns 0 with rvalid.
// - Reset asserted at RUN cycle 100 -> all outputs 0 asynchronously, state LOAD after release.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// -----------------------------------------------------------------------------
// boot_seq_pkg
// Shared types for the boot sequencer:
//   state_e  - sequencer state (3-bit encoding, exported on state_o)
//   owner_e  - which requester owned the memory grant in the previous cycle
//   ADDR_W   - width of SPI / core byte addresses
//   cnt_width() - sizes a counter able to hold the larger of two cycle counts
// -----------------------------------------------------------------------------
package boot_seq_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3
  } state_e;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_CORE = 1'b1
  } owner_e;

  // Counter width for a counter running 0..max(a,b)-1; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/boot_seq_arb.sv
// -----------------------------------------------------------------------------
// boot_seq_arb
// Single-port program-memory arbiter between the SPI-slave path and the core
// instruction-fetch port.
//   run_i                 core may be granted (sequencer in RUN)
//   spi_*                 SPI request / grant / read-return
//   core_*                core fetch request / grant / read-return
//   mem_*                 program-memory port (read data one cycle after req)
//   spi_win_o             current SPI address lies inside the memory window
//   spi_err_o             granted SPI access this cycle is outside the window
// Grants are combinational on the requests; the core has fixed priority while
// run_i is high. Out-of-window accesses are granted but never reach memory and
// return zero data.
// -----------------------------------------------------------------------------
module boot_seq_arb
  import boot_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h80,
  parameter int unsigned       MEM_WORDS = 32,
  parameter int unsigned       DATA_W    = 32,
  localparam int unsigned      AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,

  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  output logic              spi_gnt_o,
  output logic              spi_rvalid_o,
  output logic [DATA_W-1:0] spi_rdata_o,

  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              spi_win_o,
  output logic              spi_err_o
);

  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(4 * MEM_WORDS);

  // An address below BASE_ADDR wraps to a huge offset, so one unsigned
  // compare covers both window edges. BASE_ADDR is word aligned, so the low
  // two address bits never move an address across the window boundary.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return off < WIN_BYTES;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic   spi_win;
  logic   core_win;
  logic   vld_p1;
  owner_e owner_p1;
  logic   zero_p1;

  assign spi_win  = in_window(spi_addr_i);
  assign core_win = in_window(core_addr_i);

  // ---- stage p0: grant and memory strobe (combinational) ----
  assign core_gnt_o = run_i & core_req_i;
  assign spi_gnt_o  = spi_req_i & ~core_gnt_o;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_gnt_o && core_win) begin
      mem_req_o  = 1'b1;
      mem_addr_o = word_idx(core_addr_i);
    end else if (spi_gnt_o && spi_win) begin
      mem_req_o   = 1'b1;
      mem_we_o    = spi_we_i;
      mem_addr_o  = word_idx(spi_addr_i);
      mem_wdata_o = spi_we_i ? spi_wdata_i : '0;
    end
  end

  assign spi_win_o = spi_win;
  assign spi_err_o = spi_gnt_o & ~spi_win;

  // ---- stage p1: owner of the returning read data ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      owner_p1 <= OWN_SPI;
      zero_p1  <= 1'b0;
    end else begin
      vld_p1   <= core_gnt_o | (spi_gnt_o & ~spi_we_i);
      owner_p1 <= core_gnt_o ? OWN_CORE : OWN_SPI;
      zero_p1  <= core_gnt_o ? ~core_win : ~spi_win;
    end
  end

  assign spi_rvalid_o  = vld_p1 & (owner_p1 == OWN_SPI);
  assign core_rvalid_o = vld_p1 & (owner_p1 == OWN_CORE);
  assign spi_rdata_o   = (spi_rvalid_o  && !zero_p1) ? mem_rdata_i : '0;
  assign core_rdata_o  = (core_rvalid_o && !zero_p1) ? mem_rdata_i : '0;

endmodule

// File: rtl/boot_seq_ctrl.sv
// -----------------------------------------------------------------------------
// boot_seq_ctrl
// Boot sequencer: program load over SPI -> arm delay -> bounded run window ->
// GPIO grade. Owns the FSM, cycle counter and sticky flags; memory arbitration
// lives in boot_seq_arb.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   spi_*                  SPI-slave memory port (req held until gnt)
//   core_*                 core instruction-fetch port
//   mem_*                  single-port program memory
//   host_go_i              skip the end marker and arm immediately (pulse)
//   host_clear_i           return to LOAD from any state, clear flags (pulse)
//   gpio_i                 core GPIO, graded in the last run cycle
//   fetch_enable_o,
//   en_ifetch_o            core enables, high only in RUN
//   state_o                current state
//   pass_o, fail_o         sticky grade
//   addr_err_o             sticky out-of-window SPI access
// -----------------------------------------------------------------------------
module boot_seq_ctrl
  import boot_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h80,
  parameter int unsigned       MEM_WORDS  = 32,
  parameter logic [31:0]       END_MARKER = 32'h0000_0fff,
  parameter int unsigned       ARM_CYCLES = 2,
  parameter int unsigned       RUN_CYCLES = 400,
  parameter logic [31:0]       PASS_VALUE = 32'd255,
  parameter int unsigned       DATA_W     = 32,
  localparam int unsigned      AW         = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  output logic              spi_gnt_o,
  output logic              spi_rvalid_o,
  output logic [DATA_W-1:0] spi_rdata_o,

  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  input  logic              host_go_i,
  input  logic              host_clear_i,
  input  logic [31:0]       gpio_i,

  output logic              fetch_enable_o,
  output logic              en_ifetch_o,
  output logic [2:0]        state_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              addr_err_o
);

  localparam int unsigned     CNT_W    = cnt_width(ARM_CYCLES, RUN_CYCLES);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             err_q, err_d;

  logic             run;
  logic             spi_win;
  logic             spi_err;
  logic             marker_hit;

  // Enables decode straight from the state register so an asynchronous reset
  // drops them without waiting for a clock edge.
  assign run = (state_q == RUN);

  boot_seq_arb #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_WORDS (MEM_WORDS),
    .DATA_W    (DATA_W)
  ) u_arb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .run_i         (run),
    .spi_req_i     (spi_req_i),
    .spi_we_i      (spi_we_i),
    .spi_addr_i    (spi_addr_i),
    .spi_wdata_i   (spi_wdata_i),
    .spi_gnt_o     (spi_gnt_o),
    .spi_rvalid_o  (spi_rvalid_o),
    .spi_rdata_o   (spi_rdata_o),
    .core_req_i    (core_req_i),
    .core_addr_i   (core_addr_i),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .spi_win_o     (spi_win),
    .spi_err_o     (spi_err)
  );

  // The marker word is written to memory in the same granted cycle that
  // triggers the move to ARM.
  assign marker_hit = spi_gnt_o & spi_we_i & spi_win & (spi_wdata_i == END_MARKER);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q | spi_err;
    if (host_clear_i) begin
      state_d = LOAD;
      cnt_d   = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (host_go_i || marker_hit) begin
            state_d = ARM;
            cnt_d   = '0;
          end
        end
        ARM: begin
          if (cnt_q == ARM_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          // gpio_i is graded in the final enabled cycle; the flag is visible
          // together with DONE.
          if (cnt_q == RUN_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            if (gpio_i == PASS_VALUE) pass_d = 1'b1;
            else                      fail_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign fetch_enable_o = run;
  assign en_ifetch_o    = run;
  assign state_o        = state_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign addr_err_o     = err_q;

endmodule
